// File: rtl/holdem_dealer_ctrl.sv
// Hold'em dealer: shuffle, hole cards round-robin from (button+1), then burn+board per advance request.
// Latency: start_hand -> start_shuffle next cycle; one card per cycle once deck is ready; no backpressure on card output.

package holdem_pkg;
    typedef logic [5:0] card_t;
endpackage

module holdem_dealer_ctrl
    import holdem_pkg::*;
#(
    parameter int MAX_PLAYERS = 9,
    parameter int PW          = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start_hand,
    input  logic          advance,
    input  logic [PW-1:0] num_players,
    input  logic [PW-1:0] button,
    input  card_t         deck_top_card,
    input  logic          deck_ready,
    output logic          deck_start_shuffle,
    output logic          deck_draw_card,
    output logic          card_valid,
    output card_t         card_out,
    output logic          card_to_board,
    output logic [PW-1:0] card_dest,
    output logic          card_slot,
    output logic [2:0]    street,
    output logic          busy,
    output logic          hand_done
);

    typedef enum logic [3:0] {
        IDLE,
        SHUF_ISSUE,
        SHUF_WAIT,
        HOLE,
        WAIT_FLOP,
        BURN,
        BOARD,
        WAIT_TURN,
        WAIT_RIVER,
        DONE
    } state_t;

    localparam logic [PW-1:0] MIN_NP = PW'(2);
    localparam logic [PW-1:0] MAX_NP = PW'(MAX_PLAYERS);

    state_t        state;
    state_t        state_nxt;
    logic [PW-1:0] np;
    logic [PW-1:0] btn;
    logic [PW-1:0] seat;
    logic [PW:0]   hole_idx;
    logic [2:0]    bslot;

    logic [PW-1:0] np_clamp;
    logic [PW-1:0] btn_sel;
    logic [PW-1:0] first_seat;
    logic [PW-1:0] seat_next;
    logic [PW:0]   two_np_m1;
    logic          last_hole;
    logic          start_accept;

    always_comb begin
        if (num_players < MIN_NP)
            np_clamp = MIN_NP;
        else if (num_players > MAX_NP)
            np_clamp = MAX_NP;
        else
            np_clamp = num_players;
    end

    assign btn_sel      = (button < np_clamp) ? button : '0;
    assign first_seat   = (btn == np - PW'(1)) ? '0 : btn + PW'(1);
    assign seat_next    = (seat == np - PW'(1)) ? '0 : seat + PW'(1);
    assign two_np_m1    = {np, 1'b0} - (PW+1)'(1);
    assign last_hole    = (hole_idx == two_np_m1);
    // start_hand is honoured in every non-busy state; it outranks advance in the waits.
    assign start_accept = start_hand &&
                          (state inside {IDLE, DONE, WAIT_FLOP, WAIT_TURN, WAIT_RIVER});

    always_ff @(posedge clk) begin
        if (reset)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE, DONE: begin
                if (start_hand) state_nxt = SHUF_ISSUE;
            end
            WAIT_FLOP, WAIT_TURN, WAIT_RIVER: begin
                if (start_hand)   state_nxt = SHUF_ISSUE;
                else if (advance) state_nxt = BURN;
            end
            SHUF_ISSUE: state_nxt = SHUF_WAIT;
            SHUF_WAIT:  if (deck_ready) state_nxt = HOLE;
            HOLE:       if (last_hole) state_nxt = WAIT_FLOP;
            BURN:       state_nxt = BOARD;
            BOARD: begin
                case (bslot)
                    3'd2:    state_nxt = WAIT_TURN;
                    3'd3:    state_nxt = WAIT_RIVER;
                    3'd4:    state_nxt = DONE;
                    default: state_nxt = BOARD;
                endcase
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            np        <= '0;
            btn       <= '0;
            seat      <= '0;
            hole_idx  <= '0;
            bslot     <= '0;
            street    <= '0;
            hand_done <= 1'b0;
        end else begin
            if (start_accept) begin
                np        <= np_clamp;
                btn       <= btn_sel;
                bslot     <= '0;
                street    <= '0;
                hand_done <= 1'b0;
            end
            if (state == SHUF_WAIT && deck_ready) begin
                seat     <= first_seat;
                hole_idx <= '0;
            end
            if (state == HOLE) begin
                seat     <= seat_next;
                hole_idx <= hole_idx + (PW+1)'(1);
                if (last_hole) street <= 3'd1;
            end
            // bslot persists across the waits so it doubles as the street progress marker.
            if (state == BOARD) begin
                bslot <= bslot + 3'd1;
                case (bslot)
                    3'd2: street <= 3'd2;
                    3'd3: street <= 3'd3;
                    3'd4: begin
                        street    <= 3'd4;
                        hand_done <= 1'b1;
                    end
                    default: ;
                endcase
            end
        end
    end

    always_comb begin
        deck_start_shuffle = 1'b0;
        deck_draw_card     = 1'b0;
        card_valid         = 1'b0;
        card_out           = '0;
        card_to_board      = 1'b0;
        card_dest          = '0;
        card_slot          = 1'b0;
        busy               = 1'b0;
        case (state)
            SHUF_ISSUE: begin
                deck_start_shuffle = 1'b1;
                busy               = 1'b1;
            end
            SHUF_WAIT: busy = 1'b1;
            HOLE: begin
                busy           = 1'b1;
                deck_draw_card = 1'b1;
                card_valid     = 1'b1;
                card_out       = deck_top_card;
                card_dest      = seat;
                card_slot      = (hole_idx >= {1'b0, np});
            end
            BURN: begin
                busy           = 1'b1;
                deck_draw_card = 1'b1;
            end
            BOARD: begin
                busy           = 1'b1;
                deck_draw_card = 1'b1;
                card_valid     = 1'b1;
                card_out       = deck_top_card;
                card_to_board  = 1'b1;
                card_dest      = PW'(bslot);
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_holdem_dealer_ctrl.sv
// Bench for holdem_dealer_ctrl with a behavioural deck: fixed card permutation, short shuffle delay.
module tb_holdem_dealer_ctrl;
    import holdem_pkg::*;

    localparam int PW = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic          start_hand;
    logic          advance;
    logic [PW-1:0] num_players;
    logic [PW-1:0] button;
    card_t         deck_top_card;
    logic          deck_ready;
    logic          deck_start_shuffle;
    logic          deck_draw_card;
    logic          card_valid;
    card_t         card_out;
    logic          card_to_board;
    logic [PW-1:0] card_dest;
    logic          card_slot;
    logic [2:0]    street;
    logic          busy;
    logic          hand_done;

    always #5 clk = ~clk;

    holdem_dealer_ctrl #(.MAX_PLAYERS(9), .PW(PW)) dut (
        .clk                (clk),
        .reset              (reset),
        .start_hand         (start_hand),
        .advance            (advance),
        .num_players        (num_players),
        .button             (button),
        .deck_top_card      (deck_top_card),
        .deck_ready         (deck_ready),
        .deck_start_shuffle (deck_start_shuffle),
        .deck_draw_card     (deck_draw_card),
        .card_valid         (card_valid),
        .card_out           (card_out),
        .card_to_board      (card_to_board),
        .card_dest          (card_dest),
        .card_slot          (card_slot),
        .street             (street),
        .busy               (busy),
        .hand_done          (hand_done)
    );

    function automatic card_t card_at(int p);
        return card_t'((p * 7 + 3) % 52);
    endfunction

    // Deck: position 0 after shuffle, ready three cycles after the shuffle pulse.
    logic [5:0] pos;
    logic [2:0] shuf_cnt;
    always_comb deck_top_card = card_at(int'(pos));
    always @(posedge clk) begin
        if (reset) begin
            pos        <= '0;
            shuf_cnt   <= '0;
            deck_ready <= 1'b0;
        end else if (deck_start_shuffle) begin
            pos        <= '0;
            shuf_cnt   <= 3'd3;
            deck_ready <= 1'b0;
        end else begin
            if (shuf_cnt != 0) begin
                shuf_cnt <= shuf_cnt - 3'd1;
                if (shuf_cnt == 3'd1) deck_ready <= 1'b1;
            end
            if (deck_draw_card) pos <= pos + 6'd1;
        end
    end

    typedef struct packed {
        logic       shuf;
        logic       draw;
        logic       vld;
        logic       brd;
        logic [3:0] dest;
        logic       slot;
        logic [5:0] card;
        logic [2:0] st;
        logic       bsy;
        logic       done;
    } obs_t;

    typedef struct packed {
        logic sh;
        logic adv;
        obs_t exp;
    } vec_t;

    vec_t vecs[$];
    int   passed = 0;
    int   total  = 0;

    function automatic obs_t mk_obs(int shuf, int draw, int vld, int brd, int dest,
                                    int slot, int p, int st, int bsy, int done);
        obs_t o;
        o.shuf = shuf[0];
        o.draw = draw[0];
        o.vld  = vld[0];
        o.brd  = brd[0];
        o.dest = 4'(dest);
        o.slot = slot[0];
        o.card = (vld != 0) ? card_at(p) : 6'd0;
        o.st   = 3'(st);
        o.bsy  = bsy[0];
        o.done = done[0];
        return o;
    endfunction

    function automatic obs_t observe();
        obs_t o;
        o.shuf = deck_start_shuffle;
        o.draw = deck_draw_card;
        o.vld  = card_valid;
        o.brd  = card_to_board;
        o.dest = card_dest;
        o.slot = card_slot;
        o.card = card_out;
        o.st   = street;
        o.bsy  = busy;
        o.done = hand_done;
        return o;
    endfunction

    task automatic check(string name, obs_t exp);
        obs_t act;
        act = observe();
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h, required %h", name, act, exp);
    endtask

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic add(int sh, int adv, obs_t e);
        vec_t v;
        v.sh  = sh[0];
        v.adv = adv[0];
        v.exp = e;
        vecs.push_back(v);
    endtask

    task automatic wait_valid(string name);
        int n;
        n = 0;
        while (!card_valid && n < 60) begin
            step();
            n++;
        end
        total++;
        if (card_valid) passed++;
        else $display("FAIL %s: card_valid=0 after %0d cycles, required 1", name, n);
    endtask

    obs_t z;

    initial begin
        reset       = 1'b1;
        start_hand  = 1'b0;
        advance     = 1'b0;
        num_players = 4'd4;
        button      = 4'd3;
        z = mk_obs(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

        // One cycle per row: np=4, button=3 hand end to end.
        add(0, 0, z);
        add(0, 1, z);
        add(0, 1, z);
        add(1, 0, z);
        add(0, 0, mk_obs(1, 0, 0, 0, 0, 0, 0, 0, 1, 0));
        add(0, 1, mk_obs(0, 0, 0, 0, 0, 0, 0, 0, 1, 0));
        add(1, 1, mk_obs(0, 0, 0, 0, 0, 0, 0, 0, 1, 0));
        add(0, 1, mk_obs(0, 0, 0, 0, 0, 0, 0, 0, 1, 0));
        add(0, 1, mk_obs(0, 0, 0, 0, 0, 0, 0, 0, 1, 0));
        for (int i = 0; i < 8; i++)
            add((i == 3) ? 1 : 0, 1, mk_obs(0, 1, 1, 0, i % 4, (i >= 4) ? 1 : 0, i, 0, 1, 0));
        add(0, 0, mk_obs(0, 0, 0, 0, 0, 0, 0, 1, 0, 0));
        add(0, 1, mk_obs(0, 0, 0, 0, 0, 0, 0, 1, 0, 0));
        add(0, 0, mk_obs(0, 1, 0, 0, 0, 0, 0, 1, 1, 0));
        for (int i = 0; i < 3; i++)
            add(0, 0, mk_obs(0, 1, 1, 1, i, 0, 9 + i, 1, 1, 0));
        add(0, 1, mk_obs(0, 0, 0, 0, 0, 0, 0, 2, 0, 0));
        add(0, 0, mk_obs(0, 1, 0, 0, 0, 0, 0, 2, 1, 0));
        add(0, 0, mk_obs(0, 1, 1, 1, 3, 0, 13, 2, 1, 0));
        add(0, 1, mk_obs(0, 0, 0, 0, 0, 0, 0, 3, 0, 0));
        add(0, 0, mk_obs(0, 1, 0, 0, 0, 0, 0, 3, 1, 0));
        add(0, 0, mk_obs(0, 1, 1, 1, 4, 0, 15, 3, 1, 0));
        add(0, 1, mk_obs(0, 0, 0, 0, 0, 0, 0, 4, 0, 1));
        add(0, 0, mk_obs(0, 0, 0, 0, 0, 0, 0, 4, 0, 1));

        repeat (2) step();
        reset = 1'b0;

        for (int i = 0; i < vecs.size(); i++) begin
            step();
            start_hand = vecs[i].sh;
            advance    = vecs[i].adv;
            check($sformatf("vec%0d", i), vecs[i].exp);
        end
        start_hand = 1'b0;
        advance    = 1'b0;

        // Clamping: 15 players / button 12 -> np=9, btn=0, first seat 1.
        step();
        start_hand  = 1'b1;
        num_players = 4'd15;
        button      = 4'd12;
        step();
        start_hand = 1'b0;
        check("clamp_shuf", mk_obs(1, 0, 0, 0, 0, 0, 0, 0, 1, 0));
        wait_valid("clamp_first_card");
        for (int i = 0; i < 18; i++) begin
            check($sformatf("clamp_hole%0d", i),
                  mk_obs(0, 1, 1, 0, (1 + i) % 9, (i >= 9) ? 1 : 0, i, 0, 1, 0));
            step();
        end
        check("clamp_wait_flop", mk_obs(0, 0, 0, 0, 0, 0, 0, 1, 0, 0));

        // Deal the flop, then start_hand+advance together in WAIT_TURN.
        advance = 1'b1;
        step();
        advance = 1'b0;
        for (int n = 0; n < 20 && !(street == 3'd2 && !busy); n++) step();
        check("reach_wait_turn", mk_obs(0, 0, 0, 0, 0, 0, 0, 2, 0, 0));
        start_hand = 1'b1;
        advance    = 1'b1;
        step();
        start_hand = 1'b0;
        advance    = 1'b0;
        check("restart_wins", mk_obs(1, 0, 0, 0, 0, 0, 0, 0, 1, 0));

        // Reset on the third hole card of the restarted hand.
        wait_valid("restart_first_card");
        step();
        step();
        check("third_card", mk_obs(0, 1, 1, 0, 3, 0, 2, 0, 1, 0));
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("after_reset", z);
        advance = 1'b1;
        step();
        advance = 1'b0;
        check("idle_adv_after_reset", z);

        start_hand  = 1'b1;
        num_players = 4'd3;
        button      = 4'd1;
        step();
        start_hand = 1'b0;
        check("np3_shuf", mk_obs(1, 0, 0, 0, 0, 0, 0, 0, 1, 0));
        wait_valid("np3_first_card");
        for (int i = 0; i < 6; i++) begin
            check($sformatf("np3_hole%0d", i),
                  mk_obs(0, 1, 1, 0, (2 + i) % 3, (i >= 3) ? 1 : 0, i, 0, 1, 0));
            step();
        end
        check("np3_wait_flop", mk_obs(0, 0, 0, 0, 0, 0, 0, 1, 0, 0));

        // Low clamp: 1 player / button 5 -> np=2, btn=0.
        start_hand  = 1'b1;
        num_players = 4'd1;
        button      = 4'd5;
        step();
        start_hand = 1'b0;
        wait_valid("np2_first_card");
        for (int i = 0; i < 4; i++) begin
            check($sformatf("np2_hole%0d", i),
                  mk_obs(0, 1, 1, 0, (1 + i) % 2, (i >= 2) ? 1 : 0, i, 0, 1, 0));
            step();
        end
        check("np2_wait_flop", mk_obs(0, 0, 0, 0, 0, 0, 0, 1, 0, 0));

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/holdem_dealer_ctrl.md
Name: holdem_dealer_ctrl

Overview:
Sequences the shuffled card deck through one Texas Hold'em hand.
- Starts a shuffle, then deals hole cards round-robin to the players.
- Burns and deals flop, turn and river to the board, one street per `advance` request.
- Sits between the game FSM (`start_hand`/`advance`) and `card_deck` (`start_shuffle`/`draw_card`/`top_card`/`ready`).
- Emits one tagged card per cycle to the player-hand and board storage.

Parameters:
- MAX_PLAYERS, 9, highest legal player count (2..MAX_PLAYERS); 2*MAX_PLAYERS+8 must be <= 52.
- PW, 4, width of player/slot index fields.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- start_hand  in  1  begin new hand (shuffle + deal hole cards)
- advance  in  1  deal next street (flop/turn/river)
- num_players  in  PW  players in hand, sampled with start_hand
- button  in  PW  dealer button seat, sampled with start_hand
- deck_top_card  in  card_t  top_card from deck
- deck_ready  in  1  ready from deck
- deck_start_shuffle  out  1  start_shuffle to deck
- deck_draw_card  out  1  draw_card to deck
- card_valid  out  1  card_out carries a dealt card this cycle
- card_out  out  card_t  dealt card
- card_to_board  out  1  1 = board card, 0 = hole card
- card_dest  out  PW  player seat (hole) or board slot 0..4 (board)
- card_slot  out  1  hole-card index 0/1 (0 for board)
- street  out  3  0 none, 1 preflop, 2 flop, 3 turn, 4 river
- busy  out  1  shuffle or deal in progress
- hand_done  out  1  river dealt; level, held in DONE

Behaviour:
- Reset: state IDLE; all outputs 0; latched count/button cleared.
- Reset mid-hand aborts immediately, even while the deck is shuffling. The deck is reset by the same signal.

States: IDLE, SHUF_ISSUE, SHUF_WAIT, HOLE, WAIT_FLOP, BURN, BOARD, WAIT_TURN, WAIT_RIVER, DONE.
- IDLE/DONE/WAIT_*: `start_hand`=1 -> SHUF_ISSUE.
  - Latch `np` = clamp(num_players, 2, MAX_PLAYERS).
  - Latch `btn` = button if button < np, else 0.
  - `street` -> 0, `hand_done` -> 0.
- SHUF_ISSUE: `deck_start_shuffle`=1 for exactly this one cycle -> SHUF_WAIT.
- SHUF_WAIT: wait for `deck_ready`=1 -> HOLE.
  - `deck_ready` is never sampled in SHUF_ISSUE.
- HOLE: 2*np cycles, one card per cycle.
  - `card_valid`=1, `deck_draw_card`=1, `card_out` = deck_top_card (combinational).
  - `card_to_board`=0.
  - Seat sequence starts at (btn+1) mod np, increments with wrap at np.
  - `card_slot`=0 for the first np cards, 1 for the next np.
  - After the last card -> WAIT_FLOP, `street`=1.
- WAIT_FLOP/WAIT_TURN/WAIT_RIVER: `busy`=0; `advance`=1 -> BURN.
- BURN: 1 cycle, `deck_draw_card`=1, `card_valid`=0 -> BOARD.
- BOARD: 3 cards after WAIT_FLOP (slots 0,1,2), 1 card after WAIT_TURN (slot 3), 1 after WAIT_RIVER (slot 4).
  - `card_valid`=1, `card_to_board`=1, `deck_draw_card`=1.
  - On completion go to the next wait state and set `street` to 2/3/4.
  - After the river -> DONE, `hand_done`=1.
- `busy`=1 in SHUF_ISSUE, SHUF_WAIT, HOLE, BURN, BOARD.
  - `advance` and `start_hand` are ignored while busy, and `advance` is ignored in IDLE/DONE.
  - `start_hand` and `advance` high together in a wait state: `start_hand` wins.
- When `card_valid`=0: `card_out`, `card_dest`, `card_slot`, `card_to_board` are 0.
- Timing: `start_hand` sampled in cycle 0 gives `deck_start_shuffle` in cycle 1. With `card_deck`, `deck_ready` rises in cycle 54 and the first hole card is valid in cycle 55.
- Deck usage: total draws per hand = 2*np + 8 (3 burns + 5 board), and is never more than 52.

Test Plan:
- Reset: after reset, every output is 0, state IDLE, and `advance` pulses cause no deck activity.
- np=4, button=3, start_hand:
  - one `deck_start_shuffle` pulse, then 8 consecutive `card_valid` cycles in SHUF_WAIT->HOLE.
  - seats 0,1,2,3,0,1,2,3 with slots 0,0,0,0,1,1,1,1.
  - the 8 cards equal deck positions 0..7; `street`=1, `busy`=0.
- Three `advance` pulses (np=4):
  - flop: one burn cycle, then board slots 0,1,2 = deck positions 9,10,11.
  - turn: slot 3 = position 13.
  - river: slot 4 = position 15, then `hand_done`=1 and `street`=4.
- Clamping: num_players=15 and button=12 give np=9, btn=0. 18 hole cards start at seat 1 and wrap 8->0.
- Ignored and overlapping requests:
  - `advance` held high during SHUF_WAIT and HOLE has no effect.
  - `start_hand`+`advance` together in WAIT_TURN restarts the hand: `deck_start_shuffle` pulses and `street` -> 0.
- Reset asserted midway through HOLE (third card): next cycle all outputs are 0 and state IDLE. A new `start_hand` deals correctly from seat (btn+1).
